// File: rtl/keypad_pkg.sv
// Shared constants and the key map for the keypad scanner.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE  = 5'b00000;
    localparam logic [4:0] KEY_C     = 5'b11100;
    localparam logic [2:0] POS_FIRST = 3'b001;
    localparam logic [2:0] POS_LAST  = 3'b101;

    // Hex value of the key at the given row/column of the membrane keypad.
    function automatic logic [3:0] key_nibble(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [3:0] nib;
        case ({row_idx, col_idx})
            4'b00_00: nib = 4'h1;
            4'b00_01: nib = 4'h2;
            4'b00_10: nib = 4'h3;
            4'b00_11: nib = 4'hA;
            4'b01_00: nib = 4'h4;
            4'b01_01: nib = 4'h5;
            4'b01_10: nib = 4'h6;
            4'b01_11: nib = 4'hB;
            4'b10_00: nib = 4'h7;
            4'b10_01: nib = 4'h8;
            4'b10_10: nib = 4'h9;
            4'b10_11: nib = 4'hC;
            4'b11_00: nib = 4'hE;
            4'b11_01: nib = 4'h0;
            4'b11_10: nib = 4'hF;
            default:  nib = 4'hD;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Frame-rate debouncer: a candidate must repeat for DEBOUNCE consecutive
// frames before it replaces the accepted key.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic       clk5,
    input  logic       reset,
    input  logic       frame_end,
    input  logic [4:0] cand,
    output logic       accept,
    output logic [4:0] acc_key
);
    localparam logic [2:0] DB = 3'(DEBOUNCE);

    logic [4:0] prev_cand;
    logic [2:0] stable_cnt;
    logic [2:0] cnt_next;

    // Next stable count and the accept decision for the frame now ending.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = 3'd1;
        if (cand == prev_cand) begin
            cnt_next = (stable_cnt < DB) ? stable_cnt + 3'd1 : DB;
        end
        accept = frame_end && (cnt_next == DB) && (cand != acc_key);
    end

    // Per-frame history update and accepted-key register.
    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            prev_cand  <= KEY_NONE;
            stable_cnt <= 3'd0;
            acc_key    <= KEY_NONE;
        end else if (frame_end) begin
            prev_cand  <= cand;
            stable_cnt <= cnt_next;
            if (accept) begin
                acc_key <= cand;
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: drives columns, collects one candidate per frame with
// ghost rejection, debounces it, and tracks the digit position.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 2
) (
    input  logic       clk5,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] keycode,
    output logic [2:0] whichState,
    output logic       key_strobe
);
    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic              slot_last;
    logic              frame_end;

    logic [1:0] hit_cnt;      // closed contacts seen so far this frame, saturating at 2
    logic [4:0] hit_key;      // last closed contact seen this frame
    logic [2:0] slot_hits;
    logic [4:0] slot_key;
    logic [2:0] hit_sum;
    logic [1:0] merged_cnt;
    logic [4:0] merged_key;
    logic [4:0] frame_cand;

    logic       accept;
    logic [2:0] ws_next;
    logic       strobe_next;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_last && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

    // Slot and column counters: free-running, the column wraps 3 -> 0.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Merge this slot's row sample into the frame tally and form the candidate.
    always_comb begin
        slot_hits = 3'd0;
        slot_key  = KEY_NONE;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                slot_hits = slot_hits + 3'd1;
                slot_key  = {1'b1, key_nibble(2'(r), col_idx)};
            end
        end
        hit_sum    = {1'b0, hit_cnt} + slot_hits;
        merged_cnt = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        merged_key = (slot_hits != 3'd0) ? slot_key : hit_key;
        // Anything other than exactly one contact (none, or ghosting) is NONE.
        frame_cand = (merged_cnt == 2'd1) ? merged_key : KEY_NONE;
    end

    // Frame tally: accumulate on each slot's last cycle, clear at frame end.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            hit_cnt <= 2'd0;
            hit_key <= KEY_NONE;
        end else if (frame_end) begin
            hit_cnt <= 2'd0;
            hit_key <= KEY_NONE;
        end else if (slot_last) begin
            hit_cnt <= merged_cnt;
            hit_key <= merged_key;
        end
    end

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk5      (clk5),
        .reset     (reset),
        .frame_end (frame_end),
        .cand      (frame_cand),
        .accept    (accept),
        .acc_key   (keycode)
    );

    // Digit position and strobe decisions for an accept; 'C' always restarts at 1,
    // and leaving any other key advances the position.
    always_comb begin
        ws_next     = whichState;
        strobe_next = 1'b0;
        if (accept) begin
            strobe_next = (frame_cand != KEY_NONE);
            if (frame_cand == KEY_C) begin
                ws_next = POS_FIRST;
            end else if ((keycode != KEY_NONE) && (keycode != KEY_C)) begin
                ws_next = (whichState == POS_LAST) ? POS_LAST : whichState + 3'd1;
            end
        end
    end

    // Position and strobe registers, updated on the same edge as keycode.
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            whichState <= POS_FIRST;
            key_strobe <= 1'b0;
        end else begin
            whichState <= ws_next;
            key_strobe <= strobe_next;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a frame-level model driven by the set
// of closed keys, with directed scenarios followed by random key activity.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] KC   = 5'b11100;

    // Key masks: bit index is row*4 + col.
    localparam logic [15:0] M_1 = 16'h0001;
    localparam logic [15:0] M_2 = 16'h0002;
    localparam logic [15:0] M_3 = 16'h0004;
    localparam logic [15:0] M_5 = 16'h0020;
    localparam logic [15:0] M_6 = 16'h0040;
    localparam logic [15:0] M_8 = 16'h0200;
    localparam logic [15:0] M_9 = 16'h0400;
    localparam logic [15:0] M_C = 16'h0800;

    logic       clk5 = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [4:0] keycode;
    logic [2:0] whichState;
    logic       key_strobe;

    logic [15:0] pressed;

    logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    // Reference state: candidate history, accepted key and digit position.
    logic [4:0] hist [$];
    logic [4:0] m_acc;
    logic [2:0] m_ws;

    int tests  = 0;
    int fails  = 0;
    int stray  = 0;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk5       (clk5),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .keycode    (keycode),
        .whichState (whichState),
        .key_strobe (key_strobe)
    );

    always #5 clk5 = ~clk5;

    // Keypad matrix: a row is pulled low when a closed key sits on the driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4:0] cand_of(input logic [15:0] m);
        logic [4:0] c;
        c = NONE;
        if ($countones(m) == 1) begin
            for (int k = 0; k < 16; k++) begin
                if (m[k]) c = {1'b1, key_map[k]};
            end
        end
        return c;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_acc = NONE;
        m_ws  = 3'd1;
    endtask

    // Accept once the last DEBOUNCE frame candidates agree and differ from the held key.
    task automatic model_frame(input logic [15:0] mask, output logic exp_s);
        logic [4:0] c;
        logic       stable;
        c = cand_of(mask);
        hist.push_back(c);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        stable = (hist.size() == DEBOUNCE);
        foreach (hist[k]) if (hist[k] != c) stable = 1'b0;
        exp_s = 1'b0;
        if (stable && c != m_acc) begin
            if (c == KC) m_ws = 3'd1;
            else if (m_acc != NONE && m_acc != KC && m_ws < 3'd5) m_ws = m_ws + 3'd1;
            exp_s = (c != NONE);
            m_acc = c;
        end
    endtask

    // One full frame with a fixed set of closed keys, checked on its final edge.
    task automatic run_frame(input logic [15:0] mask, input string tag);
        logic [4:0] old_acc;
        logic       exp_s;
        old_acc = m_acc;
        pressed = mask;
        model_frame(mask, exp_s);
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clk5);
            #1;
            if (i == FRAME - 2) check({tag, " hold"}, 32'(keycode), 32'(old_acc));
            if (i != FRAME - 1) begin
                if (key_strobe !== 1'b0) stray++;
            end else begin
                check({tag, " keycode"}, 32'(keycode), 32'(m_acc));
                check({tag, " whichState"}, 32'(whichState), 32'(m_ws));
                check({tag, " strobe"}, 32'(key_strobe), 32'(exp_s));
            end
        end
    endtask

    task automatic press_release(input logic [15:0] mask, input int n_on, input int n_off,
                                 input string tag);
        for (int f = 0; f < n_on; f++) run_frame(mask, tag);
        for (int f = 0; f < n_off; f++) run_frame(16'h0000, tag);
    endtask

    initial begin
        logic [15:0] mask;
        int          a;
        int          b;
        int          t;

        pressed = 16'h0000;
        reset   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk5);
        check("rst col", 32'(col), 32'h0000_000E);
        check("rst keycode", 32'(keycode), 32'h0);
        check("rst whichState", 32'(whichState), 32'h1);
        check("rst strobe", 32'(key_strobe), 32'h0);
        reset = 1'b0;

        // Single press of '1' for 5 frames, release for 3.
        run_frame(M_1, "single");
        run_frame(M_1, "single");
        check("single code", 32'(keycode), 32'h11);
        press_release(M_1, 3, 3, "single");
        check("single release ws", 32'(whichState), 32'h2);

        // Clear, then the full four-digit entry.
        press_release(M_C, 3, 3, "clear0");
        press_release(M_1, 3, 3, "code1");
        press_release(M_2, 3, 3, "code2");
        press_release(M_9, 3, 3, "code9");
        press_release(M_6, 3, 3, "code6");
        check("code end ws", 32'(whichState), 32'h5);

        // Bounce: closed 1 frame, open 1, closed 3.
        press_release(M_5, 1, 1, "bounce");
        press_release(M_5, 3, 3, "bounce");

        // Ghosting: '1' and '2' together for 4 frames.
        press_release(M_1 | M_2, 4, 2, "ghost");

        // Three digits, then 'C' clears; releasing C leaves position 1.
        press_release(M_C, 3, 3, "clear1");
        press_release(M_1, 3, 3, "clr_d1");
        press_release(M_2, 3, 3, "clr_d2");
        press_release(M_3, 3, 3, "clr_d3");
        check("pre-clear ws", 32'(whichState), 32'h4);
        run_frame(M_C, "clearC");
        run_frame(M_C, "clearC");
        check("clear code", 32'(keycode), 32'h1C);
        check("clear ws", 32'(whichState), 32'h1);
        press_release(M_C, 1, 3, "clearC");

        // Direct key-to-key changes, including into 'C'.
        press_release(M_8, 3, 0, "k2k");
        press_release(M_9, 3, 0, "k2k");
        press_release(M_C, 3, 0, "k2k");
        press_release(M_5, 3, 3, "k2k");

        // Async reset mid-frame while '8' is accepted.
        press_release(M_8, 3, 0, "async");
        repeat (7) @(posedge clk5);
        #3;
        reset = 1'b1;
        #1;
        check("async col", 32'(col), 32'h0000_000E);
        check("async keycode", 32'(keycode), 32'h0);
        check("async whichState", 32'(whichState), 32'h1);
        check("async strobe", 32'(key_strobe), 32'h0);
        model_reset();
        @(negedge clk5);
        reset = 1'b0;
        press_release(M_8, 3, 3, "async");

        // Random key activity: none, single keys, 'C', and ghost pairs.
        for (int s = 0; s < 60; s++) begin
            t = $urandom_range(0, 9);
            if (t < 3) begin
                mask = 16'h0000;
            end else if (t < 8) begin
                mask = 16'h0001 << $urandom_range(0, 15);
            end else if (t == 8) begin
                a    = $urandom_range(0, 15);
                b    = (a + $urandom_range(1, 15)) % 16;
                mask = (16'h0001 << a) | (16'h0001 << b);
            end else begin
                mask = M_C;
            end
            for (int f = 0, n = $urandom_range(1, 4); f < n; f++) run_frame(mask, "rand");
        end

        check("stray strobes", 32'(stray), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans the 4x4 membrane keypad, debounces it, and reports the accepted key as a 5-bit `keycode`. It also tracks the digit position (`whichState`) for the code being entered. The block sits directly upstream of the code-comparison stage, which consumes `keycode` and `whichState` and treats `5'b11100` ('C') as clear. The scanner owns all keypad electrical timing; everything downstream sees clean, level-held key values.

## Interface
- `SCAN_DIV`, default 4: clk5 cycles each column is driven. Rows are sampled on the last cycle of each slot.
- `DEBOUNCE`, default 2: consecutive identical frames required to accept a change. Legal range is 1–7.
- `clk5`, input, 1: system clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `row`, input, 4: keypad rows, active-low, pulled up externally. A low row means the key at the driven column is closed.
- `col`, output, 4: column drive, active-low one-hot.
- `keycode`, output, 5: accepted key `{1'b1, nibble}`, or `5'b00000` when no key is accepted.
- `whichState`, output, 3: position of the digit currently being entered. Values are 1 to 4; 5 means past the end.
- `key_strobe`, output, 1: one-cycle pulse on the cycle `keycode` takes a new non-zero value.

## Operation
- **Key map (row r, column c):**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *(E), 0, #(F), D
  - The nibble is the hex value, so '1' gives `5'b10001` and 'C' gives `5'b11100`.
- **Frame:** columns 0 to 3 are driven in order, each for `SCAN_DIV` cycles, so one frame is `4*SCAN_DIV` cycles. The column counter wraps 3 to 0 continuously and never stalls.
- **Frame candidate:**
  - Exactly one closed contact in the frame: the candidate is that key.
  - Zero closed contacts: the candidate is NONE.
  - Two or more closed contacts, in the same or different columns: the candidate is NONE (ghosting rejection).
- **Debounce:**
  - At frame end, if the candidate equals the previous frame's candidate, the stable counter increments, saturating at `DEBOUNCE`. Otherwise it loads 1.
  - When the counter equals `DEBOUNCE` and the candidate differs from the accepted key, the accepted key updates.
  - `keycode` updates in the same cycle as the accepted key. It is held steady between updates.
- **`whichState` rules, applied at accept time:**
  - Accepted key becomes 'C': `whichState` goes to 1.
  - Accepted key leaves a non-C key, whether to NONE or directly to another key: `whichState` increments, saturating at 5.
  - Direct key-to-key change where the new key is 'C': the C rule wins and `whichState` goes to 1.
  - Because the increment happens on release, downstream compares each press against the position it was entered at.
- **`key_strobe`:** asserted for exactly the cycle in which `keycode` changes to a non-zero value, including direct key-to-key changes.

## Timing
- **Reset values:**
  - `col` = `4'b1110`, with the column counter and slot counter at 0
  - `keycode` = 0
  - `whichState` = 3'b001
  - `key_strobe` = 0
  - Stable counter = 0, previous candidate = NONE, accepted key = NONE
- **Reset mid-frame:** the frame in progress is discarded. Scanning restarts at column 0 on the first edge after reset deasserts.
- **Press latency:** a key closed before frame N starts and held is accepted on the final cycle of frame N+`DEBOUNCE`-1. `keycode` is valid on the next edge. With defaults this is 32 cycles after frame N starts.
- **Release latency:** symmetrical to press latency.
- **Glitches:** any glitch shorter than one full frame cannot change `keycode`.
- **Output rate:** `keycode` changes at most once per frame.

## Structure
- **Package `keypad_pkg`:**
  - `KEY_NONE` = 5'b00000, `KEY_C` = 5'b11100
  - `POS_FIRST` = 3'b001, `POS_LAST` = 3'b101
  - Function `key_nibble(row_idx, col_idx)` implementing the key map
- **Sub-module `key_debounce`:** holds the candidate register, stable counter and accepted key, and produces the change/accept flags.
- **Top `keypad_scan`:** column/slot counters, frame candidate collection with multi-key detection, and `whichState` / `key_strobe` logic.

## Test plan
- **Single press:** hold '1' (r0, c0) for 5 frames, then release for 3 frames. `keycode` goes to `5'b10001` at the cycle computed above, and `key_strobe` pulses once. After release `keycode` returns to 0 and `whichState` goes from 1 to 2.
- **Full code entry:** press and release 1, 2, 9, 6. `keycode` shows 10001, 10010, 11001, 10110 in turn, while `whichState` reads 1, 2, 3, 4 during each press. It ends at 5.
- **Bounce rejection:** close '5' for 1 frame, open for 1, then close for 3. Exactly one `key_strobe` and one accept occur.
- **Ghosting:** '1' and '2' are closed together for 4 frames. `keycode` stays 0, `whichState` is unchanged, and no strobe occurs.
- **Clear:** after 3 digits (`whichState` = 4), press 'C'. `keycode` = `5'b11100` and `whichState` = 1 on the accept cycle. Releasing C does not increment.
- **Async reset:** assert `reset` mid-frame while '8' is accepted. All outputs take their reset values immediately, without waiting for a clock edge. After deassertion with '8' still held, the key is re-accepted after `DEBOUNCE` full frames.
